fmadd_post_norm_pipe: RTL

- Pipelined, parametrised post-normalisation for the FMADD add/sub datapath.
- Takes the raw 2*MAN+4-bit sum/difference, exponent, carry and incoming G/R/S from the adder.
- Produces a normalised (MAN+2)-bit mantissa, adjusted exponent, G/R/S and status flags for the rounder.
- Adds valid/ready flow control, a two-stage pipeline, a tag sideband, zero/denormal/overflow flags and a flush input.

---
 rtl/fmadd_pn_pkg.sv | 29 ++
 rtl/fpu_lzc.sv | 23 ++
 rtl/fmadd_post_norm_pipe.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fmadd_pn_pkg.sv
// Shared configuration, derived widths and stage-1 payload for the FMADD post-normaliser.
// The format (MAN/EXP/TAG_W) is selected here; every other width is derived from it.
package fmadd_pn_pkg;

  localparam int unsigned MAN   = 22;
  localparam int unsigned EXP   = 7;
  localparam int unsigned TAG_W = 4;

  localparam int unsigned W     = 2 * MAN + 4;
  localparam int unsigned H     = MAN + 2;
  localparam int unsigned EW    = EXP + 2;
  localparam int unsigned EMAX  = (1 << (EXP + 1)) - 1;
  localparam int unsigned LZC_W = $clog2(H + 1);

  typedef struct packed {
    logic [W-1:0]     mant;    // mantissa after the first partial shift
    logic [EW-1:0]    exp;     // exponent after the first partial shift
    logic [EW-1:0]    rem;     // shift budget still available to stage 2
    logic             sub;
    logic             zero;
    logic             sticky;  // incoming G/R/S plus any dropped carry bit
    logic [TAG_W-1:0] tag;
  } s1_payload_t;

  function automatic logic [EW-1:0] min_ew(input logic [EW-1:0] a, input logic [EW-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter; returns WIDTH for an all-zero input.
module fpu_lzc #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CNT_W-1:0] o_count
);

  logic w_found;

  always_comb begin
    o_count = CNT_W'(WIDTH);
    w_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!w_found && i_data[i]) begin
        o_count = CNT_W'(WIDTH - 1 - i);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmadd_post_norm_pipe.sv
// Two-stage valid/ready post-normaliser: stage 1 does a coarse shift (or carry
// handling), stage 2 finishes the shift and extracts mantissa, G/R/S and flags.
module fmadd_post_norm_pipe
  import fmadd_pn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_mant,
  input  logic [EW-1:0]    in_exp,
  input  logic             in_carry,
  input  logic             in_eff_sub,
  input  logic             in_guard,
  input  logic             in_round,
  input  logic             in_sticky,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [H-1:0]     out_mant,
  output logic [EW-1:0]    out_exp,
  output logic             out_guard,
  output logic             out_round,
  output logic             out_sticky,
  output logic             out_zero,
  output logic             out_denorm,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  logic             r_v1, r_v2;
  logic             w_adv1, w_adv2;
  s1_payload_t      r_s1, w_s1_d;
  logic [LZC_W-1:0] w_lz1, w_lz2;
  logic [EW-1:0]    w_lim, w_sh1, w_sh2, w_e2;
  logic [W-1:0]     w_r;
  logic             w_sticky2, w_denorm2, w_ovf2;

  logic [H-1:0]     r_mant;
  logic [EW-1:0]    r_exp;
  logic             r_guard, r_round, r_sticky, r_zero, r_denorm, r_ovf;
  logic [TAG_W-1:0] r_tag;

  assign w_adv2   = !r_v2 || out_ready;
  assign w_adv1   = !r_v1 || w_adv2;
  assign in_ready = w_adv1;

  fpu_lzc #(
    .WIDTH (H),
    .CNT_W (LZC_W)
  ) u_lzc_s1 (
    .i_data  (in_mant[W-1 -: H]),
    .o_count (w_lz1)
  );

  fpu_lzc #(
    .WIDTH (H),
    .CNT_W (LZC_W)
  ) u_lzc_s2 (
    .i_data  (r_s1.mant[W-1 -: H]),
    .o_count (w_lz2)
  );

  always_comb begin
    w_s1_d = '0;
    w_lim  = (in_exp == '0) ? '0 : in_exp - EW'(1);
    w_sh1  = '0;
    if (in_eff_sub) begin
      w_sh1         = min_ew(EW'(w_lz1), w_lim);
      w_s1_d.mant   = in_mant << w_sh1;
      w_s1_d.exp    = in_exp - w_sh1;
      w_s1_d.rem    = w_lim - w_sh1;
      w_s1_d.zero   = (in_mant == '0);
      w_s1_d.sticky = in_guard | in_round | in_sticky;
    end else if (in_carry) begin
      // Carry-out becomes the new MSB; the bit pushed out the bottom folds into sticky.
      w_s1_d.mant   = {1'b1, in_mant[W-1:1]};
      w_s1_d.exp    = in_exp + EW'(1);
      w_s1_d.sticky = in_guard | in_round | in_sticky | in_mant[0];
    end else begin
      w_s1_d.mant   = in_mant;
      w_s1_d.exp    = in_exp;
      w_s1_d.sticky = in_guard | in_round | in_sticky;
    end
    w_s1_d.sub = in_eff_sub;
    w_s1_d.tag = in_tag;
  end

  // rem is zero for the add lane and after a limited stage-1 shift, so stage 2 is a no-op there.
  always_comb begin
    w_sh2     = min_ew(EW'(w_lz2), r_s1.rem);
    w_r       = r_s1.mant << w_sh2;
    w_e2      = r_s1.zero ? '0 : r_s1.exp - w_sh2;
    w_sticky2 = (|w_r[MAN-1:0]) | r_s1.sticky;
    w_denorm2 = r_s1.sub && !r_s1.zero && !w_r[W-1];
    w_ovf2    = (w_e2 >= EW'(EMAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_s1     <= '0;
      r_mant   <= '0;
      r_exp    <= '0;
      r_guard  <= 1'b0;
      r_round  <= 1'b0;
      r_sticky <= 1'b0;
      r_zero   <= 1'b0;
      r_denorm <= 1'b0;
      r_ovf    <= 1'b0;
      r_tag    <= '0;
    end else begin
      if (flush) begin
        r_v1 <= 1'b0;
        r_v2 <= 1'b0;
      end else begin
        if (w_adv1) r_v1 <= in_valid;
        if (w_adv2) r_v2 <= r_v1;
      end
      if (w_adv1 && in_valid && !flush) r_s1 <= w_s1_d;
      if (w_adv2 && r_v1 && !flush) begin
        r_mant   <= w_r[W-1 -: H];
        r_exp    <= w_e2;
        r_guard  <= w_r[MAN+1];
        r_round  <= w_r[MAN];
        r_sticky <= w_sticky2;
        r_zero   <= r_s1.zero;
        r_denorm <= w_denorm2;
        r_ovf    <= w_ovf2;
        r_tag    <= r_s1.tag;
      end
    end
  end

  assign out_valid  = r_v2;
  assign out_mant   = r_mant;
  assign out_exp    = r_exp;
  assign out_guard  = r_guard;
  assign out_round  = r_round;
  assign out_sticky = r_sticky;
  assign out_zero   = r_zero;
  assign out_denorm = r_denorm;
  assign out_ovf    = r_ovf;
  assign out_tag    = r_tag;

endmodule
